// File: rtl/lvdc_pkg.sv
// lvdc_pkg: shared types and helpers for the buffer-register sequencer.
//   state_t       - sequencer states (IDLE, CLEAR, SENSE, WAITBT, XFER, DONE)
//   *_DEFAULT     - default requester count, sense hold and transfer count
//   TR_INDEX      - transfer strobe numbering, bit 0 of tr = tr1
//   rr_pick()     - first set request at or after a pointer, wrapping
package lvdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SENSE,
    S_WAITBT,
    S_XFER,
    S_DONE
  } state_t;

  localparam int NREQ_DEFAULT         = 4;
  localparam int SENSE_CYCLES_DEFAULT = 2;
  localparam int NTR_DEFAULT          = 10;

  localparam int unsigned TR_INDEX [NTR_DEFAULT] = '{1, 2, 3, 4, 5, 7, 8, 10, 11, 13};

  // Returns the index of the first set bit of req at or after ptr, scanning
  // upward and wrapping at n. Returns 0 when nothing is set; callers qualify
  // the result with |req.
  function automatic int unsigned rr_pick(input logic [31:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned j;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      j = (ptr + k) % n;
      if (!found && req[j[4:0]]) begin
        pick  = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/bufreg_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NREQ requesters.
//   i_req    in   NREQ        request vector
//   i_ptr    in   log2(NREQ)  highest-priority index this round
//   o_onehot out  NREQ        one-hot grant candidate (0 when no request)
//   o_idx    out  log2(NREQ)  index of the candidate
//   o_any    out  1           at least one request present
// NREQ must be at least 2 and at most 32.
module rr_arbiter
  import lvdc_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_onehot,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] w_idx;

  always_comb begin
    w_idx    = IW'(rr_pick(32'(i_req), 32'(i_ptr), NREQ));
    o_any    = |i_req;
    o_idx    = w_idx;
    o_onehot = o_any ? (NREQ'(1) << w_idx) : '0;
  end

endmodule

// File: rtl/bufreg_sequencer.sv
// bufreg_sequencer: arbitrates the memory modules' read requests for the
// shared 12-bit buffer register and, per grant, drives clear, sector Y/Z
// sense sampling and the ten transfer strobes paced by the bit-time strobe.
//   clk    in   1     system clock
//   rst    in   1     synchronous active-high reset
//   bt     in   1     bit-time strobe, one clk wide
//   req    in   NREQ  read requests (level, held until ack)
//   sec_z  in   NREQ  per-requester sector select (0=Y, 1=Z), taken at grant
//   gnt    out  NREQ  one-hot grant, CLEAR through DONE
//   cbr    out  1     buffer register clear
//   sbry   out  1     sense sample, sector Y
//   sbrz   out  1     sense sample, sector Z
//   tr     out  NTR   one-hot transfer strobe, bit 0 = tr1
//   ack    out  NREQ  one-clk completion pulse
//   busy   out  1     sequence in progress
// All outputs are registered.
module bufreg_sequencer
  import lvdc_pkg::*;
#(
  parameter int NREQ         = NREQ_DEFAULT,
  parameter int SENSE_CYCLES = SENSE_CYCLES_DEFAULT,
  parameter int NTR          = NTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bt,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] sec_z,
  output logic [NREQ-1:0] gnt,
  output logic            cbr,
  output logic            sbry,
  output logic            sbrz,
  output logic [NTR-1:0]  tr,
  output logic [NREQ-1:0] ack,
  output logic            busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (SENSE_CYCLES > 1) ? $clog2(SENSE_CYCLES) : 1;
  localparam int SW = $clog2(NTR);

  state_t          r_state, w_nxt;
  logic [IW-1:0]   r_idx, w_nxt_idx, r_ptr;
  logic [NREQ-1:0] r_oh, w_nxt_oh;
  logic            r_z, w_nxt_z;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [SW-1:0]   r_step, w_nxt_step;

  logic [NREQ-1:0] w_arb_oh;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_any;

  logic [NREQ-1:0] r_gnt, w_gnt, r_ack, w_ack;
  logic            r_cbr, w_cbr, r_sbry, w_sbry, r_sbrz, w_sbrz, r_busy, w_busy;
  logic [NTR-1:0]  r_tr, w_tr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_arb_oh),
    .o_idx    (w_arb_idx),
    .o_any    (w_arb_any)
  );

  always_comb begin
    w_nxt      = r_state;
    w_nxt_idx  = r_idx;
    w_nxt_oh   = r_oh;
    w_nxt_z    = r_z;
    w_nxt_cnt  = r_cnt;
    w_nxt_step = r_step;
    case (r_state)
      S_IDLE: begin
        if (w_arb_any) begin
          w_nxt     = S_CLEAR;
          w_nxt_idx = w_arb_idx;
          w_nxt_oh  = w_arb_oh;
          w_nxt_z   = sec_z[w_arb_idx];
        end
      end
      S_CLEAR: begin
        w_nxt     = S_SENSE;
        w_nxt_cnt = '0;
      end
      S_SENSE: begin
        if (r_cnt == CW'(SENSE_CYCLES - 1)) w_nxt = S_WAITBT;
        else                                w_nxt_cnt = r_cnt + 1'b1;
      end
      S_WAITBT: begin
        if (bt) begin
          w_nxt      = S_XFER;
          w_nxt_step = '0;
        end
      end
      S_XFER: begin
        if (bt) begin
          if (r_step == SW'(NTR - 1)) w_nxt = S_DONE;
          else                        w_nxt_step = r_step + 1'b1;
        end
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the state being entered so that the output
    // flops line up with the state register rather than lagging it.
    w_busy = (w_nxt != S_IDLE);
    w_gnt  = w_busy ? w_nxt_oh : '0;
    w_cbr  = (w_nxt == S_CLEAR);
    w_sbry = (w_nxt == S_SENSE) && !w_nxt_z;
    w_sbrz = (w_nxt == S_SENSE) &&  w_nxt_z;
    w_tr   = (w_nxt == S_XFER) ? (NTR'(1) << w_nxt_step) : '0;
    w_ack  = (w_nxt == S_DONE) ? w_nxt_oh : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_oh    <= '0;
      r_z     <= 1'b0;
      r_cnt   <= '0;
      r_step  <= '0;
      r_gnt   <= '0;
      r_cbr   <= 1'b0;
      r_sbry  <= 1'b0;
      r_sbrz  <= 1'b0;
      r_tr    <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_nxt_idx;
      r_oh    <= w_nxt_oh;
      r_z     <= w_nxt_z;
      r_cnt   <= w_nxt_cnt;
      r_step  <= w_nxt_step;
      if (r_state == S_DONE)
        r_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
      r_gnt   <= w_gnt;
      r_cbr   <= w_cbr;
      r_sbry  <= w_sbry;
      r_sbrz  <= w_sbrz;
      r_tr    <= w_tr;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  assign gnt  = r_gnt;
  assign cbr  = r_cbr;
  assign sbry = r_sbry;
  assign sbrz = r_sbrz;
  assign tr   = r_tr;
  assign ack  = r_ack;
  assign busy = r_busy;

endmodule

// File: tb/tb_bufreg_sequencer.sv
// Testbench for bufreg_sequencer: directed scenarios followed by a random
// phase, every cycle compared against a transaction-level reference model.
module tb_bufreg_sequencer;

  localparam int NREQ = 4;
  localparam int SC   = 2;
  localparam int NTR  = 10;

  logic            clk = 1'b0;
  logic            rst, bt;
  logic [NREQ-1:0] req, sec_z, gnt, ack;
  logic            cbr, sbry, sbrz, busy;
  logic [NTR-1:0]  tr;

  always #5 clk = ~clk;

  bufreg_sequencer #(.NREQ(NREQ), .SENSE_CYCLES(SC), .NTR(NTR)) dut (
    .clk   (clk),
    .rst   (rst),
    .bt    (bt),
    .req   (req),
    .sec_z (sec_z),
    .gnt   (gnt),
    .cbr   (cbr),
    .sbry  (sbry),
    .sbrz  (sbrz),
    .tr    (tr),
    .ack   (ack),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_t = clocks since grant (0 = clear, 1..SC = sense),
  // m_bts = bit-time strobes accepted after sensing (k -> tr bit k-1,
  // NTR+1 -> acknowledge cycle).
  logic m_act = 1'b0;
  logic m_z   = 1'b0;
  int   m_t = 0, m_bts = 0, m_idx = 0, m_ptr = 0;

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int p);
    for (int n = 0; n < NREQ; n++)
      if (r[(p + n) % NREQ]) return (p + n) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_act <= 1'b0;
      m_ptr <= 0;
      m_t   <= 0;
      m_bts <= 0;
    end else if (!m_act) begin
      if (rr_ref(req, m_ptr) >= 0) begin
        m_act <= 1'b1;
        m_idx <= rr_ref(req, m_ptr);
        m_z   <= sec_z[rr_ref(req, m_ptr)];
        m_t   <= 0;
        m_bts <= 0;
      end
    end else if (m_bts == NTR + 1) begin
      m_act <= 1'b0;
      m_ptr <= (m_idx + 1) % NREQ;
    end else begin
      m_t <= m_t + 1;
      if (m_t > SC && bt) m_bts <= m_bts + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int             cyc = 0, bt_per = 0;
  bit             bt_rnd = 1'b0;
  int             n_cbr = 0, n_sby = 0, n_sbz = 0, n_tr = 0;
  logic [NTR-1:0] prev_tr = '0;

  task automatic clr_cnt();
    n_cbr = 0; n_sby = 0; n_sbz = 0; n_tr = 0;
  endtask

  // One clock: compare every output against the model, tally strobes,
  // then drive the bit-time strobe for the next edge.
  task automatic step();
    logic [31:0] e_gnt, e_tr, e_ack;
    logic        e_cbr, e_sby, e_sbz;
    int          ns;
    @(negedge clk);
    e_gnt = m_act ? (32'd1 << m_idx) : 32'd0;
    e_cbr = m_act && (m_t == 0);
    e_sby = m_act && (m_t >= 1) && (m_t <= SC) && !m_z;
    e_sbz = m_act && (m_t >= 1) && (m_t <= SC) &&  m_z;
    e_tr  = (m_act && m_bts >= 1 && m_bts <= NTR) ? (32'd1 << (m_bts - 1)) : 32'd0;
    e_ack = (m_act && m_bts == NTR + 1) ? (32'd1 << m_idx) : 32'd0;
    check("gnt",  32'(gnt),  e_gnt);
    check("cbr",  32'(cbr),  32'(e_cbr));
    check("sbry", 32'(sbry), 32'(e_sby));
    check("sbrz", 32'(sbrz), 32'(e_sbz));
    check("tr",   32'(tr),   e_tr);
    check("ack",  32'(ack),  e_ack);
    check("busy", 32'(busy), 32'(m_act));
    ns = int'(cbr) + int'(sbry) + int'(sbrz) + int'(tr != '0);
    check("gnt_onehot",  32'($countones(gnt) <= 1), 32'd1);
    check("strobe_excl", 32'(ns <= 1), 32'd1);
    n_cbr += int'(cbr);
    n_sby += int'(sbry);
    n_sbz += int'(sbrz);
    if (tr != '0 && tr != prev_tr) n_tr++;
    prev_tr = tr;
    cyc++;
    bt = ((bt_per != 0) && (cyc % bt_per == 0)) || (bt_rnd && $urandom_range(0, 5) == 0);
  endtask

  task automatic run_until_ack(input string tag, input int budget, output logic [NREQ-1:0] got);
    logic ok;
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (ack != '0) begin
        ok  = 1'b1;
        got = ack;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  logic [NREQ-1:0] got;
  logic [NREQ-1:0] order [5];
  logic            ok;
  int              nacks;

  initial begin
    rst = 1'b1; req = 4'hF; sec_z = '0; bt = 1'b0; bt_per = 8;

    // Reset held three clocks with every module requesting.
    repeat (3) step();
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();
    check("first_gnt", 32'(gnt), 32'h1);

    // Round robin with all requests held: A, B, C, D, A.
    for (int k = 0; k < 5; k++) begin
      run_until_ack("rr_ack_timeout", 300, got);
      order[k] = got;
      if (k == 4) req = '0;
    end
    check("rr_0", 32'(order[0]), 32'h1);
    check("rr_1", 32'(order[1]), 32'h2);
    check("rr_2", 32'(order[2]), 32'h4);
    check("rr_3", 32'(order[3]), 32'h8);
    check("rr_4", 32'(order[4]), 32'h1);
    repeat (2) step();

    // Single sector-Y read from C.
    clr_cnt();
    req = 4'b0100; sec_z = 4'b0000;
    run_until_ack("y_ack_timeout", 300, got);
    req = '0;
    check("y_ack",  32'(got),   32'h4);
    check("y_cbr",  32'(n_cbr), 32'd1);
    check("y_sbry", 32'(n_sby), 32'd2);
    check("y_sbrz", 32'(n_sbz), 32'd0);
    check("y_tr",   32'(n_tr),  32'd10);
    repeat (2) step();

    // Sector-Z read from D; sec_z flipped while sensing.
    clr_cnt();
    req = 4'b1000; sec_z = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      ok = sbrz;
    end
    check("z_sense_timeout", 32'(ok), 32'd1);
    sec_z = 4'b0000;
    run_until_ack("z_ack_timeout", 300, got);
    req = '0;
    check("z_ack",  32'(got),   32'h8);
    check("z_sbrz", 32'(n_sbz), 32'd2);
    check("z_sbry", 32'(n_sby), 32'd0);
    repeat (2) step();

    // Reset in the middle of the transfer, request kept high.
    req = 4'b0001;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step();
      ok = (tr == 10'h010);
    end
    check("tr5_timeout", 32'(ok), 32'd1);
    rst = 1'b1;
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack",  32'(ack),  32'd0);
    check("midrst_tr",   32'(tr),   32'd0);
    rst = 1'b0;
    step();
    check("regrant_gnt", 32'(gnt), 32'h1);
    check("regrant_cbr", 32'(cbr), 32'd1);
    run_until_ack("regrant_ack_timeout", 300, got);
    req = '0;
    repeat (2) step();

    // Request withdrawn right after grant; stray bt during clear and sense.
    clr_cnt();
    req = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = (gnt != '0);
    end
    check("wd_gnt_timeout", 32'(ok), 32'd1);
    req = '0;
    bt  = 1'b1;
    step(); bt = 1'b1;
    step(); bt = 1'b1;
    run_until_ack("wd_ack_timeout", 300, got);
    check("wd_ack",  32'(got),   32'h2);
    check("wd_sbry", 32'(n_sby), 32'd2);
    check("wd_tr",   32'(n_tr),  32'd10);
    repeat (2) step();

    // Random requests, sectors, withdrawals and bit-time spacing.
    bt_per = 0; bt_rnd = 1'b1; nacks = 0;
    req   = 4'($urandom_range(1, 15));
    sec_z = 4'($urandom);
    for (int i = 0; i < 3000 && nacks < 8; i++) begin
      step();
      if (ack != '0) begin
        nacks++;
        req = 4'($urandom_range(0, 15));
      end else if (req == '0 && $urandom_range(0, 3) == 0) begin
        req = 4'($urandom_range(1, 15));
      end
      if ($urandom_range(0, 9) == 0)  sec_z = 4'($urandom);
      if ($urandom_range(0, 19) == 0) req = req & 4'($urandom);
    end
    check("rand_acks", 32'(nacks), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
